// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-back control slice.
package rf_ctrl_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic {
    ARB_CORE  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for registers with loads in flight, plus the decode hazard compare.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              hazard_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_mask, clr_mask;

  // Set is applied after clear so a same-cycle issue and write-back keep the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i && (set_addr_i != '0)) set_mask[set_addr_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign hazard_o = busy_q[raddr1_i] | busy_q[raddr2_i] | (wr_en_i & busy_q[wr_addr_i]);
  assign busy_o   = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between core results and LSU load data,
// with a starvation guard that forces an LSU grant after STARVE_LIMIT losses.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_we_i,
  input  logic [REG_AW-1:0] core_waddr_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  output logic              core_stall_o,
  input  logic [REG_AW-1:0] read_addr1_i,
  input  logic [REG_AW-1:0] read_addr2_i,
  output logic              hazard_o,
  input  logic              lsu_issue_i,
  input  logic [REG_AW-1:0] lsu_issue_rd_i,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic [NREGS-1:0]  busy_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             lsu_hs;
  logic             core_grant;

  rf_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (lsu_issue_i),
    .set_addr_i (lsu_issue_rd_i),
    .clr_en_i   (lsu_hs),
    .clr_addr_i (lsu_waddr_i),
    .raddr1_i   (read_addr1_i),
    .raddr2_i   (read_addr2_i),
    .wr_en_i    (core_we_i),
    .wr_addr_i  (core_waddr_i),
    .busy_o     (busy_o),
    .hazard_o   (hazard)
  );

  assign hazard_o = hazard;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_stall_o = 1'b1;
    lsu_ready_o  = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ARB_CORE: begin
          core_stall_o = hazard;
          lsu_ready_o  = !(core_we_i && !hazard);
          if (lsu_valid_i && !lsu_ready_o) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = ARB_FORCE;
          end else begin
            cnt_d = '0;
          end
        end
        ARB_FORCE: begin
          core_stall_o = 1'b1;
          lsu_ready_o  = 1'b1;
          // Ready is forced high, so this cycle ends with a handshake or an idle LSU.
          state_d      = ARB_CORE;
          cnt_d        = '0;
        end
        default: begin
          state_d = ARB_CORE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_CORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lsu_hs     = lsu_valid_i & lsu_ready_o;
  assign core_grant = core_we_i & !core_stall_o;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_hs) begin
      rf_we_o    = (lsu_waddr_i != '0);
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (core_grant) begin
      rf_we_o    = (core_waddr_i != '0);
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: driver pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_rf_wb_arbiter;

  // Handshake: the LSU holds lsu_valid_i/addr/data until lsu_ready_o is high in
  // the same cycle; a cycle with both high is a completed write-back.

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic [4:0]  ra1, ra2;
  logic        hazard;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        lsu_valid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  localparam int W = 73;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .core_we_i      (core_we),
    .core_waddr_i   (core_waddr),
    .core_wdata_i   (core_wdata),
    .core_stall_o   (core_stall),
    .read_addr1_i   (ra1),
    .read_addr2_i   (ra2),
    .hazard_o       (hazard),
    .lsu_issue_i    (issue),
    .lsu_issue_rd_i (issue_rd),
    .lsu_valid_i    (lsu_valid),
    .lsu_waddr_i    (lsu_waddr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_ready_o    (lsu_ready),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .busy_o         (busy)
  );

  function automatic logic [W-1:0] pk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                      input logic rdy, input logic st, input logic hz,
                                      input logic [31:0] b);
    return {we, a, d, rdy, st, hz, b};
  endfunction

  task automatic idle();
    core_we = 0; core_waddr = 0; core_wdata = 0; ra1 = 0; ra2 = 0;
    issue = 0; issue_rd = 0; lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
  endtask

  task automatic core(input logic [4:0] a, input logic [31:0] d);
    core_we = 1; core_waddr = a; core_wdata = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid = 1; lsu_waddr = a; lsu_wdata = d;
  endtask

  task automatic expect_out(input string nm, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic rdy, input logic st,
                            input logic hz, input logic [31:0] b);
    exp_q.push_back(pk(we, a, d, rdy, st, hz, b));
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: address/data are only compared when a write is expected.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a, m;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = pk(rf_we, rf_waddr, rf_wdata, lsu_ready, core_stall, hazard, busy);
      m  = e[72] ? {W{1'b1}} : {1'b1, 37'b0, 35'h7_FFFF_FFFF};
      total++;
      if ((a & m) !== (e & m)) begin
        bad++;
        $display("FAIL %s: got we=%b addr=%0d data=%h rdy=%b stall=%b haz=%b busy=%h, want we=%b addr=%0d data=%h rdy=%b stall=%b haz=%b busy=%h",
                 nm, a[72], a[71:67], a[66:35], a[34], a[33], a[32], a[31:0],
                 e[72], e[71:67], e[66:35], e[34], e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    idle();
    tick();
    expect_out("reset", 0, 0, 0, 0, 1, 0, 32'h0);
    tick();
    rst = 0;

    // Single core write-back.
    core(5, 32'h0000_1234);
    expect_out("core_x5", 1, 5, 32'h0000_1234, 0, 0, 0, 32'h0);
    tick();

    // Starvation guard: LSU loses three cycles, then is forced through.
    for (int i = 0; i < 3; i++) begin
      idle(); core(6, 32'h100 + i); lsu(7, 32'hDEAD_BEEF);
      expect_out("starve_lose", 1, 6, 32'h100 + i, 0, 0, 0, 32'h0);
      tick();
    end
    idle(); core(6, 32'h200); lsu(7, 32'hDEAD_BEEF);
    expect_out("starve_force", 1, 7, 32'hDEAD_BEEF, 1, 1, 0, 32'h0);
    tick();
    idle(); core(6, 32'h300);
    expect_out("starve_back_core", 1, 6, 32'h300, 0, 0, 0, 32'h0);
    tick();

    // Load hazard on x10, cleared the cycle after write-back.
    idle(); issue = 1; issue_rd = 10; ra1 = 10;
    expect_out("haz_issue", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();
    idle(); ra1 = 10; core(3, 32'h33);
    expect_out("haz_c1_stall", 0, 0, 0, 1, 1, 1, 32'h0000_0400);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); ra1 = 10;
      expect_out("haz_hold", 0, 0, 0, 1, 1, 1, 32'h0000_0400);
      tick();
    end
    idle(); ra1 = 10; lsu(10, 32'h0000_CAFE);
    expect_out("haz_wb_no_bypass", 1, 10, 32'h0000_CAFE, 1, 1, 1, 32'h0000_0400);
    tick();
    idle(); ra1 = 10;
    expect_out("haz_cleared", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();

    // x0 handling.
    idle(); core(0, 32'h55);
    expect_out("core_x0", 0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    idle(); issue = 1; issue_rd = 0;
    expect_out("issue_x0", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();
    idle(); lsu(0, 32'h77);
    expect_out("lsu_x0", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();

    // Same-cycle set and clear of x12: set wins.
    idle(); issue = 1; issue_rd = 12;
    expect_out("x12_issue", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();
    idle(); issue = 1; issue_rd = 12; lsu(12, 32'h12);
    expect_out("x12_set_clr", 1, 12, 32'h12, 1, 0, 0, 32'h0000_1000);
    tick();
    idle(); lsu(12, 32'h13);
    expect_out("x12_set_wins", 1, 12, 32'h13, 1, 0, 0, 32'h0000_1000);
    tick();
    idle();
    expect_out("x12_cleared", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();

    // Async reset while in ARB_FORCE with x10 busy.
    idle(); issue = 1; issue_rd = 10;
    expect_out("rst_setup", 0, 0, 0, 1, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); core(5, 32'h1); lsu(9, 32'h99);
      expect_out("rst_lose", 1, 5, 32'h1, 0, 0, 0, 32'h0000_0400);
      tick();
    end
    idle(); core(5, 32'h1); lsu(9, 32'h99);
    expect_out("rst_async", 0, 0, 0, 0, 1, 0, 32'h0);
    #1 rst = 1;
    tick();
    rst = 0;
    idle(); core(5, 32'h2); lsu(9, 32'h99);
    expect_out("rst_release_core", 1, 5, 32'h2, 0, 0, 0, 32'h0);
    tick();
    idle(); lsu(9, 32'h99);
    expect_out("rst_lsu_drain", 1, 9, 32'h99, 1, 0, 0, 32'h0);
    tick();
    idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
